// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// PC step, end-of-program word and the PC legality check.
package rv_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        FAULT = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    // A PC is unusable if it is not word aligned or lies beyond the
    // instruction memory's byte-address space (2**aw bytes).
    function automatic logic pc_bad(input logic [31:0] pc, input int unsigned aw);
        return (pc[1:0] != 2'b00) || ((pc >> aw) != 32'd0);
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: drives a combinational instruction ROM, presents
// one instruction at a time to decode with a valid/ready handshake, and
// reacts to redirects, illegal PCs (fault) and the all-zero end word (halt).
// Optional build macro IF_PREFETCH_EN: in VALID the ROM is addressed with
// pc+4 so an accepted instruction is replaced in the same cycle, giving one
// instruction per cycle instead of one per two cycles.
module if_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_dout,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [31:0]      ir_instr,
    output logic [31:0]      ir_pc,
    output logic             fault,
    output logic             halted
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_inc;
    logic         handshake;

    assign pc_inc    = pc + PC_INC;
    assign handshake = ir_valid & ir_ready;

`ifdef IF_PREFETCH_EN
    // While an instruction is on offer, look one word ahead so it can be
    // replaced on the accepting edge.
    always_comb begin
        im_addr = (state == VALID) ? pc_inc[IM_AW-1:0] : pc[IM_AW-1:0];
    end
`else
    assign im_addr = pc[IM_AW-1:0];
`endif

    // Fetch FSM: redirect wins over everything, including a same-cycle
    // handshake, which is then considered consumed without a PC step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir_valid <= 1'b0;
            ir_instr <= 32'd0;
            ir_pc    <= 32'd0;
            fault    <= 1'b0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            ir_valid <= 1'b0;
            fault    <= 1'b0;
            halted   <= 1'b0;
            state    <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (pc_bad(pc, IM_AW)) begin
                        fault    <= 1'b1;
                        ir_valid <= 1'b0;
                        state    <= FAULT;
                    end else if (im_dout == HALT_WORD) begin
                        halted   <= 1'b1;
                        ir_valid <= 1'b0;
                        state    <= HALT;
                    end else begin
                        ir_instr <= im_dout;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        state    <= VALID;
                    end
                end
                VALID: begin
                    if (handshake) begin
                        pc <= pc_inc;
`ifdef IF_PREFETCH_EN
                        if (pc_bad(pc_inc, IM_AW)) begin
                            fault    <= 1'b1;
                            ir_valid <= 1'b0;
                            state    <= FAULT;
                        end else if (im_dout == HALT_WORD) begin
                            halted   <= 1'b1;
                            ir_valid <= 1'b0;
                            state    <= HALT;
                        end else begin
                            ir_instr <= im_dout;
                            ir_pc    <= pc_inc;
                            ir_valid <= 1'b1;
                        end
`else
                        ir_valid <= 1'b0;
                        state    <= FETCH;
`endif
                    end
                end
                default: begin
                    // FAULT and HALT wait for a redirect or reset.
                end
            endcase
        end
    end

endmodule
